// File: rtl/serdes_link.sv
// serdes_link: serial link endpoint, one framed transmitter and one SOF-aligned receiver
module serdes_link #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] TX_DIN,
   input  logic             TX_VALID,
   output logic             TX_READY,
   output logic             SOF_OUT,
   output logic             SOUT,
   output logic             TX_BUSY,
   input  logic             SOF_IN,
   input  logic             SIN,
   output logic [WIDTH-1:0] RX_DOUT,
   output logic             RX_VALID,
   output logic             RX_ERR
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam int P0 = MSB_FIRST ? WIDTH - 1 : 0;

   typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
   typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;

   tx_state_t        tx_st, tx_nx;
   logic [CW-1:0]    tcnt, tcnt_nx;
   logic [WIDTH-1:0] tsr, tsr_nx;
   logic             sof_nx, sout_nx, accept;

   rx_state_t        rx_st, rx_nx;
   logic [CW-1:0]    rcnt, rcnt_nx, ridx;
   logic [WIDTH-1:0] rbuf, rbuf_nx, dout_nx;
   logic             valid_nx, err_nx;

   // the last bit cycle can accept the next word so frames chain with no gap
   assign TX_READY = !RST && (tx_st == TX_IDLE || tcnt == LAST);
   assign accept   = TX_VALID && TX_READY;
   assign TX_BUSY  = (tx_st == TX_SHIFT);
   assign ridx     = MSB_FIRST ? LAST - rcnt : rcnt;

   // TX next state: SOUT is registered, so the first bit leaves on the accept edge and tsr keeps the rest
   always_comb begin
      tx_nx   = tx_st;
      tcnt_nx = tcnt;
      tsr_nx  = tsr;
      sof_nx  = 1'b0;
      sout_nx = 1'b0;
      if (accept) begin
         tx_nx   = TX_SHIFT;
         tcnt_nx = '0;
         sof_nx  = 1'b1;
         sout_nx = MSB_FIRST ? TX_DIN[WIDTH-1] : TX_DIN[0];
         tsr_nx  = MSB_FIRST ? TX_DIN << 1 : TX_DIN >> 1;
      end else if (tx_st == TX_SHIFT) begin
         if (tcnt == LAST) begin
            tx_nx   = TX_IDLE;
            tcnt_nx = '0;
         end else begin
            tcnt_nx = tcnt + 1'b1;
            sout_nx = MSB_FIRST ? tsr[WIDTH-1] : tsr[0];
            tsr_nx  = MSB_FIRST ? tsr << 1 : tsr >> 1;
         end
      end
   end

   // TX state register
   always_ff @(posedge CLK) begin
      if (RST) begin
         tx_st   <= TX_IDLE;
         tcnt    <= '0;
         tsr     <= '0;
         SOF_OUT <= 1'b0;
         SOUT    <= 1'b0;
      end else begin
         tx_st   <= tx_nx;
         tcnt    <= tcnt_nx;
         tsr     <= tsr_nx;
         SOF_OUT <= sof_nx;
         SOUT    <= sout_nx;
      end
   end

   // RX next state: SOF always restarts a frame at bit 0, and flags an error if one was in progress
   always_comb begin
      rx_nx    = rx_st;
      rcnt_nx  = rcnt;
      rbuf_nx  = rbuf;
      dout_nx  = RX_DOUT;
      valid_nx = 1'b0;
      err_nx   = 1'b0;
      if (SOF_IN) begin
         err_nx      = (rx_st == RX_RECV);
         rbuf_nx     = '0;
         rbuf_nx[P0] = SIN;
         rcnt_nx     = CW'(1);
         rx_nx       = RX_RECV;
      end else if (rx_st == RX_RECV) begin
         rbuf_nx[ridx] = SIN;
         if (rcnt == LAST) begin
            dout_nx  = rbuf_nx;
            valid_nx = 1'b1;
            rcnt_nx  = '0;
            rx_nx    = RX_IDLE;
         end else begin
            rcnt_nx = rcnt + 1'b1;
         end
      end
   end

   // RX state register
   always_ff @(posedge CLK) begin
      if (RST) begin
         rx_st    <= RX_IDLE;
         rcnt     <= '0;
         rbuf     <= '0;
         RX_DOUT  <= '0;
         RX_VALID <= 1'b0;
         RX_ERR   <= 1'b0;
      end else begin
         rx_st    <= rx_nx;
         rcnt     <= rcnt_nx;
         rbuf     <= rbuf_nx;
         RX_DOUT  <= dout_nx;
         RX_VALID <= valid_nx;
         RX_ERR   <= err_nx;
      end
   end
endmodule

// File: tb/tb_serdes_link.sv
// tb_serdes_link: directed checks of an 8-bit LSB-first and a 12-bit MSB-first loopback endpoint
module tb_serdes_link;
   logic clk = 1'b0;
   logic rst;
   logic loop, d_sof, d_sin;
   logic [7:0] a_din, a_dout;
   logic a_valid, a_ready, a_sof_out, a_sout, a_busy, a_sof_in, a_sin, a_rx_valid, a_err;
   logic [11:0] b_din, b_dout;
   logic b_valid, b_ready, b_sof_out, b_sout, b_busy, b_rx_valid, b_err;
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   assign a_sof_in = loop ? a_sof_out : d_sof;
   assign a_sin    = loop ? a_sout : d_sin;

   serdes_link #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_a (
      .CLK(clk), .RST(rst), .TX_DIN(a_din), .TX_VALID(a_valid), .TX_READY(a_ready),
      .SOF_OUT(a_sof_out), .SOUT(a_sout), .TX_BUSY(a_busy), .SOF_IN(a_sof_in), .SIN(a_sin),
      .RX_DOUT(a_dout), .RX_VALID(a_rx_valid), .RX_ERR(a_err));

   serdes_link #(.WIDTH(12), .MSB_FIRST(1'b1)) dut_b (
      .CLK(clk), .RST(rst), .TX_DIN(b_din), .TX_VALID(b_valid), .TX_READY(b_ready),
      .SOF_OUT(b_sof_out), .SOUT(b_sout), .TX_BUSY(b_busy), .SOF_IN(b_sof_out), .SIN(b_sout),
      .RX_DOUT(b_dout), .RX_VALID(b_rx_valid), .RX_ERR(b_err));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int c = 0; c < 3; c++) begin
         step();
         checks++; if ({a_ready, a_sof_out, a_sout, a_busy, a_rx_valid, a_err, a_dout} !== '0) begin errors++; $display("FAIL reset_a cyc%0d got %h want 0", c, {a_ready, a_sof_out, a_sout, a_busy, a_rx_valid, a_err, a_dout}); end
         checks++; if ({b_ready, b_sof_out, b_sout, b_busy, b_rx_valid, b_err, b_dout} !== '0) begin errors++; $display("FAIL reset_b cyc%0d got %h want 0", c, {b_ready, b_sof_out, b_sout, b_busy, b_rx_valid, b_err, b_dout}); end
      end
      rst = 1'b0; a_valid = 1'b0; d_sof = 1'b0; d_sin = 1'b0;
      #1;
      checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset_a got %b want 1", a_ready); end
      checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset_b got %b want 1", b_ready); end
      loop = 1'b1;
      step();
   endtask

   task automatic test_lsb_single();
      logic [7:0] w = 8'hA5;
      a_din = w; a_valid = 1'b1;
      step();
      a_valid = 1'b0; a_din = 8'h00;
      for (int i = 0; i < 8; i++) begin
         checks++; if (a_sout !== w[i]) begin errors++; $display("FAIL a5_sout bit%0d got %b want %b", i, a_sout, w[i]); end
         checks++; if (a_sof_out !== (i == 0)) begin errors++; $display("FAIL a5_sof bit%0d got %b want %b", i, a_sof_out, i == 0); end
         checks++; if (a_rx_valid !== 1'b0) begin errors++; $display("FAIL a5_early_valid bit%0d got %b want 0", i, a_rx_valid); end
         step();
      end
      checks++; if (a_rx_valid !== 1'b1) begin errors++; $display("FAIL a5_rx_valid got %b want 1", a_rx_valid); end
      checks++; if (a_dout !== 8'hA5) begin errors++; $display("FAIL a5_rx_dout got %h want a5", a_dout); end
      checks++; if ({a_busy, a_sout} !== 2'b00) begin errors++; $display("FAIL a5_idle got %b want 00", {a_busy, a_sout}); end
      step();
      checks++; if (a_rx_valid !== 1'b0) begin errors++; $display("FAIL a5_valid_pulse got %b want 0", a_rx_valid); end
      checks++; if (a_dout !== 8'hA5) begin errors++; $display("FAIL a5_dout_hold got %h want a5", a_dout); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] w = 16'hC33C;
      a_din = 8'h3C; a_valid = 1'b1;
      step();
      a_din = 8'hC3;
      for (int i = 0; i < 16; i++) begin
         checks++; if (a_sout !== w[i]) begin errors++; $display("FAIL b2b_sout bit%0d got %b want %b", i, a_sout, w[i]); end
         checks++; if (a_sof_out !== (i % 8 == 0)) begin errors++; $display("FAIL b2b_sof bit%0d got %b want %b", i, a_sof_out, i % 8 == 0); end
         checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL b2b_err bit%0d got %b want 0", i, a_err); end
         checks++; if (a_rx_valid !== (i == 8)) begin errors++; $display("FAIL b2b_valid bit%0d got %b want %b", i, a_rx_valid, i == 8); end
         if (i == 8) begin
            checks++; if (a_dout !== 8'h3C) begin errors++; $display("FAIL b2b_first_word got %h want 3c", a_dout); end
            a_valid = 1'b0;
         end
         step();
      end
      checks++; if (a_rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_second_valid got %b want 1", a_rx_valid); end
      checks++; if (a_dout !== 8'hC3) begin errors++; $display("FAIL b2b_second_word got %h want c3", a_dout); end
      checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got %b want 0", a_busy); end
      step();
   endtask

   task automatic test_msb12();
      logic [11:0] w = 12'h801;
      b_din = w; b_valid = 1'b1;
      step();
      b_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         checks++; if (b_sout !== w[11-i]) begin errors++; $display("FAIL msb_sout bit%0d got %b want %b", i, b_sout, w[11-i]); end
         checks++; if (b_sof_out !== (i == 0)) begin errors++; $display("FAIL msb_sof bit%0d got %b want %b", i, b_sof_out, i == 0); end
         checks++; if (b_rx_valid !== 1'b0) begin errors++; $display("FAIL msb_early_valid bit%0d got %b want 0", i, b_rx_valid); end
         step();
      end
      checks++; if (b_rx_valid !== 1'b1) begin errors++; $display("FAIL msb_rx_valid got %b want 1", b_rx_valid); end
      checks++; if (b_dout !== 12'h801) begin errors++; $display("FAIL msb_rx_dout got %h want 801", b_dout); end
      checks++; if ({b_busy, b_err} !== 2'b00) begin errors++; $display("FAIL msb_idle got %b want 00", {b_busy, b_err}); end
      step();
   endtask

   task automatic test_framing_error();
      logic [7:0] w = 8'h5A;
      loop = 1'b0;
      d_sof = 1'b1; d_sin = 1'b1;
      step();
      d_sof = 1'b0;
      for (int i = 1; i < 4; i++) begin
         step();
         checks++; if ({a_err, a_rx_valid} !== 2'b00) begin errors++; $display("FAIL fe_partial bit%0d got %b want 00", i, {a_err, a_rx_valid}); end
      end
      d_sof = 1'b1; d_sin = w[0];
      step();
      checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL fe_err got %b want 1", a_err); end
      checks++; if (a_rx_valid !== 1'b0) begin errors++; $display("FAIL fe_no_valid got %b want 0", a_rx_valid); end
      d_sof = 1'b0;
      for (int i = 1; i < 8; i++) begin
         d_sin = w[i];
         step();
         checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL fe_err_pulse bit%0d got %b want 0", i, a_err); end
         checks++; if (a_rx_valid !== (i == 7)) begin errors++; $display("FAIL fe_valid bit%0d got %b want %b", i, a_rx_valid, i == 7); end
         if (i < 7) begin
            checks++; if (a_dout !== 8'hC3) begin errors++; $display("FAIL fe_dout_hold bit%0d got %h want c3", i, a_dout); end
         end
      end
      checks++; if (a_dout !== 8'h5A) begin errors++; $display("FAIL fe_dout got %h want 5a", a_dout); end
      d_sin = 1'b0; loop = 1'b1;
      step();
   endtask

   task automatic test_mid_reset();
      a_din = 8'hF0; a_valid = 1'b1;
      step();
      a_valid = 1'b0;
      repeat (3) step();
      checks++; if ({a_busy, a_sout} !== 2'b10) begin errors++; $display("FAIL mr_bit3 got %b want 10", {a_busy, a_sout}); end
      rst = 1'b1;
      step();
      checks++; if ({a_ready, a_sof_out, a_sout, a_busy, a_rx_valid, a_err, a_dout} !== '0) begin errors++; $display("FAIL mr_reset got %h want 0", {a_ready, a_sof_out, a_sout, a_busy, a_rx_valid, a_err, a_dout}); end
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step();
         checks++; if ({a_rx_valid, a_err, a_sout, a_sof_out} !== 4'b0000) begin errors++; $display("FAIL mr_quiet cyc%0d got %b want 0000", c, {a_rx_valid, a_err, a_sout, a_sof_out}); end
      end
      a_din = 8'h0F; a_valid = 1'b1;
      step();
      a_valid = 1'b0;
      repeat (8) step();
      checks++; if (a_rx_valid !== 1'b1) begin errors++; $display("FAIL mr_next_valid got %b want 1", a_rx_valid); end
      checks++; if (a_dout !== 8'h0F) begin errors++; $display("FAIL mr_next_word got %h want 0f", a_dout); end
      checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL mr_next_err got %b want 0", a_err); end
   endtask

   initial begin
      rst = 1'b1; loop = 1'b0; d_sof = 1'b1; d_sin = 1'b1;
      a_valid = 1'b1; a_din = 8'hFF; b_valid = 1'b0; b_din = '0;
      test_reset();
      test_lsb_single();
      test_back_to_back();
      test_msb12();
      test_framing_error();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/serdes_link.md
Name: serdes_link

Overview:
Parameterised serial link endpoint containing one transmitter and one receiver. The transmitter accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock, marking the first bit of each frame with a one-cycle SOF strobe. The receiver rebuilds words from the serial stream using that SOF strobe and reports word-complete and framing-error events. The block supports LSB-first or MSB-first bit order, back-to-back frames with no gap, and SOUT->SIN / SOF_OUT->SOF_IN loopback.

Parameters:
WIDTH, 8, word width in bits; legal range 2..32.
MSB_FIRST, 0, 0 = bit 0 sent/received first; 1 = bit WIDTH-1 sent/received first.

Ports:
CLK  in  1  single clock; all logic on rising edge
RST  in  1  synchronous reset, active-high
TX_DIN  in  WIDTH  word to transmit
TX_VALID  in  1  TX_DIN valid
TX_READY  out  1  transmitter can accept a word this cycle
SOF_OUT  out  1  high during the cycle SOUT carries the first bit of a frame
SOUT  out  1  serial data out
TX_BUSY  out  1  transmitter is in SHIFT state
SOF_IN  in  1  receive frame start; high during the cycle SIN carries the first bit
SIN  in  1  serial data in
RX_DOUT  out  WIDTH  last complete received word
RX_VALID  out  1  one-cycle pulse: RX_DOUT updated
RX_ERR  out  1  one-cycle pulse: framing error

Behaviour:
- Reset: synchronous, active-high, on CLK rising edge. It takes priority over every other event.
  - Reset values: all registered outputs are 0 (SOF_OUT, SOUT, TX_BUSY, RX_DOUT, RX_VALID, RX_ERR).
  - TX_READY is 0 while RST=1.
  - Both FSMs go to IDLE and both bit counters go to 0.
  - Reset mid-frame aborts the frame. The partial TX word is discarded, and the partial RX word is discarded with no RX_VALID and no RX_ERR.
- TX FSM, states IDLE and SHIFT; bit counter tcnt runs 0..WIDTH-1.
  - TX_READY = !RST && (IDLE || (SHIFT && tcnt==WIDTH-1)). It is combinational from registers only, never from TX_VALID.
  - A word is accepted on an edge where TX_VALID && TX_READY. On that edge: load the shift register with TX_DIN, set tcnt=0, state=SHIFT.
  - In the cycle after acceptance: SOF_OUT=1 and SOUT = first bit (TX_DIN[0] if MSB_FIRST=0, else TX_DIN[WIDTH-1]).
  - Each following edge shifts one bit and increments tcnt. SOF_OUT is 1 for exactly one cycle per frame.
  - On the edge ending bit WIDTH-1:
    - if a new word is accepted, the next frame starts immediately (no idle bit; SOF_OUT high again);
    - otherwise state=IDLE, SOUT=0.
  - TX_BUSY=1 exactly in SHIFT. SOUT=0 whenever IDLE.
  - TX_DIN is sampled only on the accept edge; later changes have no effect.
- RX FSM, states IDLE and RECV; bit counter rcnt.
  - In IDLE: SIN is ignored unless SOF_IN=1. With SOF_IN=1, the edge stores SIN as received bit 0, sets rcnt=1, state=RECV.
  - In RECV with SOF_IN=0: store SIN as bit rcnt and increment rcnt.
  - Bit placement:
    - MSB_FIRST=0: received bit i goes to word position i.
    - MSB_FIRST=1: received bit i goes to word position WIDTH-1-i.
  - On the edge storing bit WIDTH-1:
    - copy the assembled word to RX_DOUT; RX_VALID=1 for the next cycle only;
    - state=IDLE.
    - A SOF_IN on the very next cycle is a legal back-to-back frame.
  - SOF_IN=1 while in RECV (rcnt in 1..WIDTH-1) is a framing error:
    - RX_ERR=1 for the next cycle;
    - partial word discarded, no RX_VALID;
    - this SIN is taken as bit 0 of a new frame, rcnt=1, state stays RECV.
  - RX_DOUT holds its value until the next complete word or reset.
- Latency, loopback, WIDTH=W: RX_VALID is high in the cycle after edge k+W, where k is the TX accept edge. Back-to-back throughput is 1 word per W cycles.
- TX and RX are independent. Simultaneous TX accept and RX events need no arbitration.

Test Plan:
- Reset: hold RST 3 cycles with TX_VALID=1, SOF_IN=1 -> TX_READY=0 and all outputs 0 during reset; TX_READY=1 the cycle after release.
- WIDTH=8, MSB_FIRST=0, loopback, send 0xA5 -> SOUT=1,0,1,0,0,1,0,1 with SOF_OUT on the first bit only; RX_VALID one cycle high 8 cycles after the accept edge; RX_DOUT=0xA5; TX_BUSY low afterwards.
- Back-to-back: hold TX_VALID with 0x3C then 0xC3 -> 16 consecutive SOUT bits with no gap; SOF_OUT pulses 8 cycles apart; RX_VALID pulses 8 cycles apart with 0x3C then 0xC3; RX_ERR never set.
- MSB_FIRST=1, WIDTH=12, loopback, send 0x801 -> SOUT=1, ten 0s, then 1; RX_DOUT=0x801 with RX_VALID 12 cycles after the accept edge.
- Framing error: drive SOF_IN directly, bits of 0xFF, then reassert SOF_IN at bit 4 and send 0x5A -> RX_ERR pulse one cycle after that edge; no RX_VALID for the partial word; RX_VALID with RX_DOUT=0x5A 8 cycles after the second SOF.
- Mid-frame reset: assert RST for 1 cycle at TX bit 3 of 0xF0 in loopback -> SOUT=0, SOF_OUT=0, no RX_VALID or RX_ERR; the next word 0x0F completes normally with RX_DOUT=0x0F.
